// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding,
// parameter limits and width helpers.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_HOLD = 2'd0,
    RS_RUN  = 2'd1,
    RS_DONE = 2'd2
  } rs_state_e;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;
  localparam int DELAY_MIN  = 1;
  localparam int DELAY_MAX  = 65535;
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;

  // Counter/index widths never collapse to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic bit params_ok(input int stages, input int delay, input int sync);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
           (delay  >= DELAY_MIN)  && (delay  <= DELAY_MAX)  &&
           (sync   >= SYNC_MIN)   && (sync   <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asynchronous assertion, deassertion after SYNC edges.
module reset_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic resetn,
  output logic srst_n
);

  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign srst_n = sync_q[SYNC-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: synchronizes the global reset, then
// releases STAGES active-low resets in order, DELAY cycles apart.
//
// state   | meaning
// RS_HOLD | synchronizer still asserting; first clean edge starts counting
// RS_RUN  | counting towards the next stage release
// RS_DONE | every stage released, waiting for a soft request
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int DELAY  = 16,
  parameter int SYNC   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_req,
  output logic [STAGES-1:0] stage_rstn,
  output logic              done,
  output logic              busy
);

  localparam int CW = clog2_min1(DELAY);
  localparam int IW = clog2_min1(STAGES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  generate
    if (!params_ok(STAGES, DELAY, SYNC)) begin : g_param_err
      $error("reset_sequencer: STAGES/DELAY/SYNC outside legal range");
    end
  endgenerate

  logic srst_n;

  reset_sync #(.SYNC(SYNC)) u_reset_sync (
    .clk    (clk),
    .resetn (resetn),
    .srst_n (srst_n)
  );

  rs_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [STAGES-1:0] stage_q, stage_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              advance;
  logic              restart;

  always_comb begin
    advance = 1'b0;
    restart = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    busy_d  = busy_q;

    // The hold edge is already the first counting edge, so a stage
    // releases exactly DELAY edges after the synchronizer lets go.
    case (state_q)
      RS_HOLD: advance = 1'b1;
      RS_RUN: begin
        if (soft_req) restart = 1'b1;
        else          advance = 1'b1;
      end
      RS_DONE: restart = soft_req;
      default: state_d = RS_HOLD;
    endcase

    if (restart) begin
      state_d = RS_RUN;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (advance) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        idx_d = idx_q + 1'b1;
        for (int i = 0; i < STAGES; i++) begin
          stage_d[i] = stage_q[i] | (idx_q == IW'(i));
        end
        if (idx_q == IDX_LAST) begin
          state_d = RS_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = RS_RUN;
        end
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = RS_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= RS_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign stage_rstn = stage_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameter sets checked every cycle against
// an edge-count model, plus directed scenarios pinned by literal values.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_v [3];
  logic soft_v [3];

  logic [2:0] st_a;
  logic [0:0] st_b;
  logic [3:0] st_c;
  logic done_a, done_b, done_c;
  logic busy_a, busy_b, busy_c;

  reset_sequencer #(.STAGES(3), .DELAY(16), .SYNC(2)) dut_a (
    .clk(clk), .resetn(rstn_v[0]), .soft_req(soft_v[0]),
    .stage_rstn(st_a), .done(done_a), .busy(busy_a)
  );

  reset_sequencer #(.STAGES(1), .DELAY(1), .SYNC(2)) dut_b (
    .clk(clk), .resetn(rstn_v[1]), .soft_req(soft_v[1]),
    .stage_rstn(st_b), .done(done_b), .busy(busy_b)
  );

  reset_sequencer #(.STAGES(4), .DELAY(3), .SYNC(3)) dut_c (
    .clk(clk), .resetn(rstn_v[2]), .soft_req(soft_v[2]),
    .stage_rstn(st_c), .done(done_c), .busy(busy_c)
  );

  function automatic int p_st(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 4;
  endfunction
  function automatic int p_dl(input int i);
    return (i == 0) ? 16 : (i == 1) ? 1 : 3;
  endfunction
  function automatic int p_sy(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic logic [9:0] lit(input int s, input bit d, input bit b);
    return {8'(s), d, b};
  endfunction

  function automatic logic [9:0] act(input int i);
    case (i)
      0:       return {5'd0, st_a, done_a, busy_a};
      1:       return {7'd0, st_b, done_b, busy_b};
      default: return {4'd0, st_c, done_c, busy_c};
    endcase
  endfunction

  // Model: each sequence has a start edge; released stage count is simply
  // elapsed edges divided by DELAY, saturated at STAGES.
  int cyc = 0;
  int m_sync  [3];
  int m_start [3];
  int m_hold  [3];
  bit m_valid [3];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rstn_v[i] !== 1'b1) begin
        m_sync[i]  = 0;
        m_valid[i] = 1'b0;
      end else if (!m_valid[i]) begin
        m_sync[i]++;
        if (m_sync[i] == p_sy(i)) begin
          m_valid[i] = 1'b1;
          m_start[i] = cyc;
          m_hold[i]  = cyc + 1;
        end
      end else if (soft_v[i] && cyc > m_hold[i]) begin
        m_start[i] = cyc;
      end
    end
  end

  function automatic logic [9:0] model_exp(input int i);
    int n;
    if (rstn_v[i] !== 1'b1 || !m_valid[i]) return lit(0, 1'b0, 1'b1);
    n = (cyc - m_start[i]) / p_dl(i);
    if (n > p_st(i)) n = p_st(i);
    return lit((1 << n) - 1, n == p_st(i), n != p_st(i));
  endfunction

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [9:0] a, e;
        a = act(i);
        e = model_exp(i);
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL model_cmp inst=%0d cyc=%0d got=%h want=%h", i, cyc, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [9:0] a, input logic [9:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  int rh [3];
  int sh [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn_v[i] = 1'b0;
      soft_v[i] = 1'b0;
      rh[i] = 0;
      sh[i] = 0;
    end
    tick(3);
    chk_en = 1'b1;
    chk("reset_a", act(0), lit(0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;

    // power-up: edge E is the one just passed
    tick(2);  chk("b_e2",  act(1), lit(0, 1'b0, 1'b1));
    tick(1);  chk("b_e3",  act(1), lit(1, 1'b1, 1'b0));
    tick(14); chk("a_e17", act(0), lit(0, 1'b0, 1'b1));
    tick(1);  chk("a_e18", act(0), lit(1, 1'b0, 1'b1));
    tick(16); chk("a_e34", act(0), lit(3, 1'b0, 1'b1));
    tick(15); chk("a_e49", act(0), lit(3, 1'b0, 1'b1));
    tick(1);  chk("a_e50", act(0), lit(7, 1'b1, 1'b0));

    // one-cycle soft request from RS_DONE
    tick(5);
    soft_v[0] = 1'b1;
    tick(1);  soft_v[0] = 1'b0;
    chk("a_soft_r",   act(0), lit(0, 1'b0, 1'b1));
    tick(15); chk("a_soft_r15", act(0), lit(0, 1'b0, 1'b1));
    tick(1);  chk("a_soft_r16", act(0), lit(1, 1'b0, 1'b1));

    // soft request at cycle 20 of that sequence
    tick(3);
    soft_v[0] = 1'b1;
    tick(1);  soft_v[0] = 1'b0;
    chk("a_mid_r",   act(0), lit(0, 1'b0, 1'b1));
    tick(15); chk("a_mid_r15", act(0), lit(0, 1'b0, 1'b1));
    tick(1);  chk("a_mid_r16", act(0), lit(1, 1'b0, 1'b1));

    // soft request held for 10 samples
    soft_v[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("a_held", act(0), lit(0, 1'b0, 1'b1));
    end
    soft_v[0] = 1'b0;
    tick(15); chk("a_held_h15", act(0), lit(0, 1'b0, 1'b1));
    tick(1);  chk("a_held_h16", act(0), lit(1, 1'b0, 1'b1));

    // global reset pulse at cycle 25, seen before the next edge
    tick(9);
    rstn_v[0] = 1'b0;
    #1;
    chk("a_async", act(0), lit(0, 1'b0, 1'b1));
    tick(1);
    rstn_v[0] = 1'b1;
    tick(17); chk("a_rel17", act(0), lit(0, 1'b0, 1'b1));
    tick(1);  chk("a_rel18", act(0), lit(1, 1'b0, 1'b1));
    tick(32); chk("a_rel50", act(0), lit(7, 1'b1, 1'b0));

    // single-stage, single-cycle soft restart
    soft_v[1] = 1'b1;
    tick(1);  soft_v[1] = 1'b0;
    chk("b_soft_r",  act(1), lit(0, 1'b0, 1'b1));
    tick(1);  chk("b_soft_r1", act(1), lit(1, 1'b1, 1'b0));

    // random reset pulses and soft requests on all instances
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      for (int i = 0; i < 3; i++) begin
        if (rh[i] > 0) begin
          rh[i]--;
          if (rh[i] == 0) rstn_v[i] = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          rstn_v[i] = 1'b0;
          rh[i] = int'($urandom_range(1, 3));
        end
        if (sh[i] > 0) begin
          sh[i]--;
          if (sh[i] == 0) soft_v[i] = 1'b0;
        end else if ($urandom_range(0, 79) == 0) begin
          soft_v[i] = 1'b1;
          sh[i] = int'($urandom_range(1, 12));
        end
      end
    end

    for (int i = 0; i < 3; i++) begin
      rstn_v[i] = 1'b1;
      soft_v[i] = 1'b0;
    end
    tick(60);
    chk("a_final", act(0), lit(7, 1'b1, 1'b0));
    chk("c_final", act(2), lit(15, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
